cdc_handshake_tx: RTL

Source-domain initiator of a four-phase request/acknowledge handshake that carries a DATA_WIDTH-bit word into another clock domain. It accepts a word on a valid/ready interface and launches it on a held bus (`xdata_o`). It raises `req_o` only after a programmable settle interval, and returns to ready only after the destination's `ack_i`, synchronized locally, has completed a full high/low cycle. The destination side samples `req_o` through its own two-stage synchronizer and captures `xdata_o`, which is guaranteed stable while `req_o` is high.

---
 rtl/cdc_handshake_tx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cdc_handshake_tx.sv
// Source-side initiator of a four-phase req/ack handshake.
// A word accepted on valid/ready is launched on a held bus. req rises after a
// programmable settle interval. The block returns to ready once the
// synchronized ack has gone high and then low again.
module cdc_handshake_tx #(
    parameter int unsigned           DATA_WIDTH   = 8,
    parameter int unsigned           SETUP_CYCLES = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_DATA    = '0
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] xdata_o,
    output logic                  req_o,
    input  logic                  ack_i
);

    // The settle counter is 4 bits wide, so the interval is limited to 1..15.
    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
        $error("cdc_handshake_tx: SETUP_CYCLES must be within 1..15");
    end

    localparam logic [3:0] CNT_LOAD = 4'(SETUP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RESYNC  = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_REQ     = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Synchronizer and state registers
    logic                  r_ack_meta;
    logic                  r_ack_s;
    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_xdata;
    logic                  r_ready;
    logic                  r_req;
    logic                  r_done;

    // Next-state decode
    state_t                w_state_nxt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_load;
    logic                  w_ready_nxt;
    logic                  w_req_nxt;
    logic                  w_done_nxt;

    // Two-flop ack synchronizer. Both stages reset high, so a leftover ack
    // from an aborted transfer has to be seen low before the block goes idle.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_ack_meta <= 1'b1;
            r_ack_s    <= 1'b1;
        end else begin
            r_ack_meta <= ack_i;
            r_ack_s    <= r_ack_meta;
        end
    end

    // Next-state and output decode. Outputs are derived from the next state
    // and registered, so no input reaches an output combinationally.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            ST_RESYNC: begin
                if (!r_ack_s) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (valid_i) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_cnt == 4'd0) w_state_nxt = ST_REQ;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            ST_REQ: begin
                if (r_ack_s) w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!r_ack_s) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_RESYNC;
        endcase
        w_ready_nxt = (w_state_nxt == ST_IDLE);
        w_req_nxt   = (w_state_nxt == ST_REQ);
        // done only marks a completed handshake, not the exit from RESYNC
        w_done_nxt  = (r_state == ST_RELEASE) && (w_state_nxt == ST_IDLE);
    end

    // State, counter, held data bus and registered outputs
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= ST_RESYNC;
            r_cnt   <= 4'd0;
            r_xdata <= INIT_DATA;
            r_ready <= 1'b0;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) r_xdata <= data_i;
            r_ready <= w_ready_nxt;
            r_req   <= w_req_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign ready_o = r_ready;
    assign done_o  = r_done;
    assign xdata_o = r_xdata;
    assign req_o   = r_req;

endmodule
